face_scan_ctrl: RTL

Sequencing controller for the cube-scanning datapath. It consumes the nine per-frame facelet colour codes produced by the colour classifier and requires a face to read identically for a configurable number of consecutive frames. Each stable face is written into the 54-entry cube-state memory, and the block then waits for the user to present the next face. After six faces it flags the cube as ready for the solver.

---
 rtl/scan_pkg.sv | 42 ++++
 rtl/face_scan_ctrl_stability.sv | 75 +++++++
 rtl/face_scan_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_pkg
//  Description : Shared colour codes, FSM state encoding and cube geometry for
//                the cube-scanning controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    // Facelet colour codes; only WHITE..BLUE are legal classifier results
    localparam logic [3:0] COL_NONE   = 4'd0;
    localparam logic [3:0] COL_WHITE  = 4'd1;
    localparam logic [3:0] COL_RED    = 4'd2;
    localparam logic [3:0] COL_ORANGE = 4'd3;
    localparam logic [3:0] COL_YELLOW = 4'd4;
    localparam logic [3:0] COL_GREEN  = 4'd5;
    localparam logic [3:0] COL_BLUE   = 4'd6;

    localparam int NUM_FACES   = 6;
    localparam int FACELETS    = 9;
    localparam int CUBE_ADDR_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SAMPLE    = 3'd1,
        ST_WRITE     = 3'd2,
        ST_WAIT_USER = 3'd3,
        ST_DONE      = 3'd4
    } scan_state_t;

    function automatic logic code_valid(input logic [3:0] code);
        return (code >= COL_WHITE) && (code <= COL_BLUE);
    endfunction

    // face*9 + idx, built from a shift-add so no multiplier is implied
    function automatic logic [CUBE_ADDR_W-1:0] cube_addr(input logic [2:0] face,
                                                         input logic [3:0] idx);
        return ({3'b000, face} << 3) + {3'b000, face} + {2'b00, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/face_scan_ctrl_stability.sv
`default_nettype none
// ============================================================================
//  Module      : facelet_stability
//  Description : Holds the last valid frame snapshot and counts consecutive
//                identical valid frames; flags a lock on the strobe where the
//                updated count reaches STABLE_FRAMES.
//  Revision    : 1.0 - initial release
// ============================================================================
module facelet_stability
    import scan_pkg::*;
#(
    parameter int STABLE_FRAMES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_strobe,
    input  logic [4*FACELETS-1:0]   i_facelets,
    output logic [4*FACELETS-1:0]   o_snapshot,
    output logic                    o_locked
);

    localparam logic [7:0] c_stable = 8'(STABLE_FRAMES);

    logic [4*FACELETS-1:0] r_snapshot;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_upd;
    logic                  w_all_valid;
    logic                  w_match;

    // A frame is usable only if every one of the nine codes is a real colour
    always_comb begin
        w_all_valid = 1'b1;
        for (int i = 0; i < FACELETS; i++) begin
            if (!code_valid(i_facelets[4*i +: 4])) begin
                w_all_valid = 1'b0;
            end
        end
    end

    assign w_match = (i_facelets == r_snapshot);

    // Count value this strobe would produce (saturates at 255)
    always_comb begin
        if (!w_all_valid) begin
            w_cnt_upd = 8'd0;
        end else if (w_match) begin
            w_cnt_upd = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
        end else begin
            w_cnt_upd = 8'd1;
        end
    end

    assign o_locked   = i_strobe & w_all_valid & (w_cnt_upd >= c_stable);
    assign o_snapshot = r_snapshot;

    // Snapshot reloads on any new valid frame; clear overrides the count update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snapshot <= '0;
            r_cnt      <= 8'd0;
        end else begin
            if (i_strobe && w_all_valid && !w_match) begin
                r_snapshot <= i_facelets;
            end
            if (i_clr) begin
                r_cnt <= 8'd0;
            end else if (i_strobe) begin
                r_cnt <= w_cnt_upd;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/face_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : face_scan_ctrl
//  Description : Six-face scan sequencer. Waits for a stable face, bursts its
//                nine facelets into cube memory, then waits for the user to
//                rotate the cube. Flags cube_ready after the sixth face.
//  Options     : SCAN_CENTER_CHECK_EN - reject a face whose centre colour was
//                already captured on an earlier face (pulses dup_err).
//  Revision    : 1.0 - initial release
// ============================================================================
module face_scan_ctrl
    import scan_pkg::*;
#(
    parameter int STABLE_FRAMES = 8
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    start,
    input  logic                    next,
    input  logic                    abort,
    input  logic                    frame_strobe,
    input  logic [4*FACELETS-1:0]   facelets,
    output logic                    wr_en,
    output logic [CUBE_ADDR_W-1:0]  wr_addr,
    output logic [3:0]              wr_data,
    output logic [2:0]              face_idx,
    output logic                    busy,
    output logic                    face_locked,
    output logic                    cube_ready,
    output logic                    dup_err
);

    localparam logic [2:0] c_last_face = 3'(NUM_FACES - 1);
    localparam logic [3:0] c_last_idx  = 4'(FACELETS - 1);

    scan_state_t           r_state, w_state_nxt;
    logic [2:0]            r_face_idx, w_face_nxt;
    logic [3:0]            r_idx, w_idx_nxt;
    logic                  w_clr;
    logic                  w_strobe;
    logic                  w_locked;
    logic [4*FACELETS-1:0] w_snapshot;
    logic [3:0]            w_wr_data;
    logic                  r_busy, r_face_locked, r_cube_ready;

`ifdef SCAN_CENTER_CHECK_EN
    logic [6:0]            r_mask;
    logic                  r_dup;
    logic                  w_dup;
    logic                  w_mask_set;
    logic                  w_mask_clr;
    logic [2:0]            w_centre;

    // Valid codes are 1..6, so the low three bits of the middle code index the mask
    assign w_centre = facelets[18:16];
`endif

    // Frames only count while sampling, and abort masks them outright
    assign w_strobe = frame_strobe & (r_state == ST_SAMPLE) & ~abort;

    facelet_stability #(
        .STABLE_FRAMES (STABLE_FRAMES)
    ) u_stability (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .i_clr      (w_clr),
        .i_strobe   (w_strobe),
        .i_facelets (facelets),
        .o_snapshot (w_snapshot),
        .o_locked   (w_locked)
    );

    // Next-state, face/index sequencing and counter clear requests
    always_comb begin
        w_state_nxt = r_state;
        w_face_nxt  = r_face_idx;
        w_idx_nxt   = r_idx;
        w_clr       = 1'b0;
`ifdef SCAN_CENTER_CHECK_EN
        w_dup       = 1'b0;
        w_mask_set  = 1'b0;
        w_mask_clr  = 1'b0;
`endif
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_face_nxt  = 3'd0;
            w_idx_nxt   = 4'd0;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_state_nxt = ST_SAMPLE;
                        w_face_nxt  = 3'd0;
                        w_idx_nxt   = 4'd0;
                        w_clr       = 1'b1;
`ifdef SCAN_CENTER_CHECK_EN
                        w_mask_clr  = 1'b1;
`endif
                    end
                end
                ST_SAMPLE: begin
                    if (w_locked) begin
`ifdef SCAN_CENTER_CHECK_EN
                        if (r_mask[w_centre]) begin
                            w_dup = 1'b1;
                            w_clr = 1'b1;
                        end else begin
                            w_mask_set  = 1'b1;
                            w_state_nxt = ST_WRITE;
                            w_idx_nxt   = 4'd0;
                        end
`else
                        w_state_nxt = ST_WRITE;
                        w_idx_nxt   = 4'd0;
`endif
                    end
                end
                ST_WRITE: begin
                    if (r_idx == c_last_idx) begin
                        w_idx_nxt   = 4'd0;
                        w_state_nxt = (r_face_idx == c_last_face) ? ST_DONE : ST_WAIT_USER;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
                ST_WAIT_USER: begin
                    if (next) begin
                        w_state_nxt = ST_SAMPLE;
                        w_face_nxt  = r_face_idx + 3'd1;
                        w_clr       = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, face and burst index registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_face_idx <= 3'd0;
            r_idx      <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_face_idx <= w_face_nxt;
            r_idx      <= w_idx_nxt;
        end
    end

    // Status flags registered from the next state so they track the state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_busy        <= 1'b0;
            r_face_locked <= 1'b0;
            r_cube_ready  <= 1'b0;
        end else begin
            r_busy        <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            r_face_locked <= (w_state_nxt == ST_WAIT_USER);
            r_cube_ready  <= (w_state_nxt == ST_DONE);
        end
    end

`ifdef SCAN_CENTER_CHECK_EN
    // Centre-colour history and the one-cycle duplicate pulse
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mask <= 7'd0;
            r_dup  <= 1'b0;
        end else begin
            r_dup <= w_dup;
            if (w_mask_clr) begin
                r_mask <= 7'd0;
            end else if (w_mask_set) begin
                r_mask[w_centre] <= 1'b1;
            end
        end
    end

    assign dup_err = r_dup;
`else
    assign dup_err = 1'b0;
`endif

    // Select the snapshot code for the current burst position
    always_comb begin
        w_wr_data = 4'd0;
        for (int i = 0; i < FACELETS; i++) begin
            if (r_idx == 4'(i)) begin
                w_wr_data = w_snapshot[4*i +: 4];
            end
        end
    end

    // Memory port is driven only during the burst so it idles at zero
    assign wr_en       = (r_state == ST_WRITE);
    assign wr_addr     = wr_en ? cube_addr(r_face_idx, r_idx) : '0;
    assign wr_data     = wr_en ? w_wr_data : 4'd0;
    assign face_idx    = r_face_idx;
    assign busy        = r_busy;
    assign face_locked = r_face_locked;
    assign cube_ready  = r_cube_ready;

endmodule
`default_nettype wire
